// File: rtl/spi_serf_pkg.sv
// Shared types and frame geometry for the spi_serf SPI responder.
package spi_serf_pkg;
  typedef enum logic [2:0] {ARM, IDLE, CMD, DATA, FULL} state_t;
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int RW_BIT     = 15;
endpackage

// File: rtl/spi_serf_sync.sv
// Two-flop synchronizer followed by an edge-detect flop for one SPI pin.
module spi_serf_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_serf.sv
// SPI responder: 16-bit frames (R/W, 7-bit address, 8-bit data) against a small register map.
module spi_serf
  import spi_serf_pkg::*;
#(
  parameter logic [6:0] ID_ADDR   = 7'h0F,
  parameter logic [7:0] ID_VAL    = 8'h6A,
  parameter int         MAP_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic       wr_strb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       xfer_done
);
  localparam int         AW     = $clog2(MAP_DEPTH);
  localparam int         CW     = $clog2(FRAME_BITS);
  localparam logic [7:0] DEPTH8 = 8'(MAP_DEPTH);

  // index 0 = SS_n, 1 = SCLK, 2 = MOSI
  logic [2:0] lvl, rse, fll;
  spi_serf_sync u_sync [2:0] (
    .clk  (clk),
    .rst  (rst),
    .din  ({MOSI, SCLK, SS_n}),
    .level(lvl),
    .rise (rse),
    .fall (fll)
  );

  logic ss_lvl, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi;
  assign ss_lvl    = lvl[0];
  assign ss_rise   = rse[0];
  assign ss_fall   = fll[0];
  assign sclk_rise = rse[1];
  assign sclk_fall = fll[1];
  assign mosi      = lvl[2];

  logic unused_sync;
  assign unused_sync = lvl[1] ^ rse[2] ^ fll[2];

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [7:0]      rx, tx;
  logic            rw;
  logic [6:0]      addr;
  logic [7:0]      map [MAP_DEPTH];
  logic [7:0]      cmd_byte, rd_sel;
  logic            writable;

  assign cmd_byte = {rx[6:0], mosi};
  assign writable = (addr != ID_ADDR) && ({1'b0, addr} < DEPTH8);

  always_comb begin
    rd_sel = '0;
    if (cmd_byte[6:0] == ID_ADDR)               rd_sel = ID_VAL;
    else if ({1'b0, cmd_byte[6:0]} < DEPTH8)    rd_sel = map[cmd_byte[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARM;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ARM:  if (ss_lvl) nxt = IDLE;
      IDLE: if (ss_fall) nxt = CMD;
      CMD:  if (sclk_rise && cnt == CW'(CMD_BITS - 1)) nxt = DATA;
      DATA: if (sclk_rise && cnt == CW'(FRAME_BITS - 1)) nxt = FULL;
      FULL: nxt = FULL;
      default: nxt = ARM;
    endcase
    // SS_n rising always ends the frame; only FULL frames commit below
    if (ss_rise) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      MISO      <= 1'b0;
      wr_strb   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      xfer_done <= 1'b0;
      for (int i = 0; i < MAP_DEPTH; i++) map[i] <= '0;
    end else begin
      wr_strb   <= 1'b0;
      xfer_done <= 1'b0;
      if (ss_rise) begin
        MISO <= 1'b0;
        if (state == FULL) begin
          xfer_done <= 1'b1;
          if (!rw && writable) begin
            map[addr[AW-1:0]] <= rx;
            wr_addr           <= addr;
            wr_data           <= rx;
            wr_strb           <= 1'b1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            MISO <= 1'b0;
            if (ss_fall) cnt <= '0;
          end
          CMD, DATA: begin
            if (sclk_rise) begin
              rx  <= cmd_byte;
              cnt <= cnt + 1'b1;
              if (state == CMD && cnt == CW'(CMD_BITS - 1)) begin
                rw   <= cmd_byte[RW_BIT - CMD_BITS];
                addr <= cmd_byte[6:0];
                // writes load zeros so MISO stays low through the data phase
                tx   <= cmd_byte[RW_BIT - CMD_BITS] ? rd_sel : 8'h00;
              end
            end
            if (sclk_fall && state == DATA) begin
              MISO <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
          end
          FULL: if (sclk_fall) MISO <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_serf.sv
// Scoreboard bench for spi_serf: the bench acts as SPI initiator, a monitor checks strobes and read bytes.
module tb_spi_serf;
  localparam int H = 8;

  logic       clk = 1'b0, rst = 1'b1;
  logic       SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
  logic       MISO, wr_strb, xfer_done;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  spi_serf dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data), .xfer_done(xfer_done)
  );

  typedef struct {
    logic       is_rd;
    logic [7:0] rd;
  } exp_t;

  exp_t        exp_q [$];
  logic [14:0] wr_q  [$];
  logic [7:0]  model [128];
  logic [7:0]  cap_byte = 8'h00;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] ref_read(input logic [6:0] a);
    if (a == 7'h0F) return 8'h6A;
    if (a < 7'd16)  return model[a];
    return 8'h00;
  endfunction

  task automatic chk_reset_outs(input string name);
    chk(name, {MISO, wr_strb, xfer_done, wr_addr, wr_data}, 16'h0000);
  endtask

  // one initiator transaction; nbits<16 aborts, rst_bit>=0 pulses reset before that bit
  task automatic frame(input logic [15:0] f, input int nbits, input int rst_bit);
    logic [7:0] got = 8'h00;
    logic       is_rd = f[15];
    logic [6:0] a = f[14:8];
    @(negedge clk);
    SS_n = 1'b0;
    clk_n(H);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_bit) begin
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_mid_frame");
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        clk_n(3);
        rst = 1'b0;
      end
      SCLK = 1'b0;
      MOSI = f[15-k];
      clk_n(H);
      if (k >= 8 && is_rd && rst_bit < 0) got = {got[6:0], MISO};
      else chk("miso_low", 16'(MISO), 16'h0000);
      SCLK = 1'b1;
      clk_n(H);
    end
    clk_n(4);
    if (nbits == 16 && rst_bit < 0) begin
      cap_byte = got;
      exp_q.push_back('{is_rd: is_rd, rd: ref_read(a)});
      if (!is_rd && a != 7'h0F && a < 7'd16) begin
        wr_q.push_back({a, f[7:0]});
        model[a] = f[7:0];
      end
    end
    SS_n = 1'b1;
    clk_n(12);
    chk("miso_idle", 16'(MISO), 16'h0000);
  endtask

  // monitor: every xfer_done pops a frame record, every wr_strb pops a write record
  always @(negedge clk) begin
    if (!rst) begin
      if (xfer_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer_done got=1 exp=0 at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_rd) chk("rd_data", 16'(cap_byte), 16'(e.rd));
        end
      end
      if (wr_strb) begin
        chk("strb_with_done", 16'(xfer_done), 16'h0001);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr_strb got addr=%h data=%h exp none at %0t", wr_addr, wr_data, $time);
        end else begin
          logic [14:0] w;
          w = wr_q.pop_front();
          chk("wr_addr", 16'(wr_addr), 16'(w[14:8]));
          chk("wr_data", 16'(wr_data), 16'(w[7:0]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    clk_n(3);
    chk_reset_outs("reset_hold");
    rst = 1'b0;
    clk_n(6);
    chk_reset_outs("reset_release");

    frame(16'h8F00, 16, -1);                 // identity
    frame(16'h0D02, 16, -1);
    frame(16'h8D00, 16, -1);
    frame(16'h0355, 11, -1);                 // abort in data phase
    frame(16'h8300, 16, -1);
    frame(16'h0FAA, 16, -1);                 // protected
    frame(16'h30BB, 16, -1);                 // out of range
    frame(16'h8F00, 16, -1);
    frame(16'hB000, 16, -1);
    frame(16'h0A7E, 16, 5);                  // reset mid-frame
    frame(16'h8A00, 16, -1);
    for (int i = 0; i < 4; i++) frame({8'(i), 8'(8'hA0 + i)}, 16, -1);
    for (int i = 0; i < 4; i++) frame({8'(8'h80 + i), 8'h00}, 16, -1);

    for (int n = 0; n < 24; n++) begin
      logic [6:0] a;
      logic       rd;
      int         nb;
      a  = ($urandom_range(0, 3) == 0) ? 7'h0F : 7'($urandom_range(0, 31));
      rd = 1'($urandom_range(0, 1));
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 16;
      frame({rd, a, 8'($urandom_range(0, 255))}, nb, -1);
    end
    for (int i = 0; i < 16; i++) frame({1'b1, 7'(i), 8'h00}, 16, -1);

    clk_n(20);
    chk("exp_q_drained", 16'(exp_q.size()), 16'h0000);
    chk("wr_q_drained", 16'(wr_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
